// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline hazard controller:
// controller state encoding, default register address width and the
// bit positions of the ID/EX control word.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_RUN,
        ST_STALL,
        ST_FLUSH,
        ST_FREEZE
    } hz_state_t;

    localparam int unsigned REG_AW_DEF = 3;

    // Control word bit positions as carried in the ID/EX register
    localparam int unsigned CB_REG_WRITE   = 0;
    localparam int unsigned CB_MEM_TO_REG  = 1;
    localparam int unsigned CB_SIMPLE_JUMP = 2;
    localparam int unsigned CB_BNE         = 3;
    localparam int unsigned CB_MEM_WRITE   = 4;
    localparam int unsigned CB_ALU_OP_LSB  = 5;
    localparam int unsigned CB_ALU_OP_MSB  = 6;
    localparam int unsigned CB_ALU_SRC     = 7;
    localparam int unsigned CTRL_W         = 8;

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: shadow copy of the destination registers held in
// EX, MEM and WB. Flags a RAW hazard when the instruction in ID reads a
// register still owned by an in-flight producer.
module hazard_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned WB_SPLIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_hold,
    input  logic              i_kill,
    input  logic              i_load,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic              i_use_rs1,
    input  logic              i_use_rs2,
    input  logic [REG_AW-1:0] i_rd,
    output logic              o_hazard
);

    logic              r_ex_v, r_mem_v, r_wb_v;
    logic [REG_AW-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
    logic              w_chk_wb, w_hit1, w_hit2;

    // Slots advance with the pipeline; a flush kills the EX entry on its
    // way to MEM while the MEM entry still retires into WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_v   <= 1'b0;
            r_mem_v  <= 1'b0;
            r_wb_v   <= 1'b0;
            r_ex_rd  <= '0;
            r_mem_rd <= '0;
            r_wb_rd  <= '0;
        end else if (!i_hold) begin
            r_wb_v   <= r_mem_v;
            r_wb_rd  <= r_mem_rd;
            r_mem_v  <= r_ex_v & ~i_kill;
            r_mem_rd <= r_ex_rd;
            r_ex_v   <= i_load & i_id_valid & ~i_kill;
            r_ex_rd  <= i_rd;
        end
    end

    // Compare ID sources against the valid producer slots
    always_comb begin
        w_chk_wb = (WB_SPLIT == 0) && r_wb_v;
        w_hit1   = i_use_rs1 && ((r_ex_v  && (r_ex_rd  == i_rs1)) ||
                                 (r_mem_v && (r_mem_rd == i_rs1)) ||
                                 (w_chk_wb && (r_wb_rd == i_rs1)));
        w_hit2   = i_use_rs2 && ((r_ex_v  && (r_ex_rd  == i_rs2)) ||
                                 (r_mem_v && (r_mem_rd == i_rs2)) ||
                                 (w_chk_wb && (r_wb_rd == i_rs2)));
        o_hazard = i_id_valid && (w_hit1 || w_hit2);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/freeze sequencing for the 16-bit
// 5-stage pipeline. Optional perf counters enabled by HAZ_PERF_CNT_EN;
// without it stall_cnt/flush_cnt read zero and no counter flops exist.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned WB_SPLIT = 1,
    parameter int unsigned FILL_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              mem_pcsrc,
    input  logic              mem_busy,
    output logic              pc_we,
    output logic              if_id_we,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              pipe_freeze,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    localparam int unsigned     FCW       = (FILL_CYC > 1) ? $clog2(FILL_CYC) : 1;
    localparam logic [FCW-1:0]  FILL_INIT = FCW'(FILL_CYC - 1);

    hz_state_t      r_state, w_state_nxt, w_case;
    logic [FCW-1:0] r_fill_cnt, w_fill_cnt_nxt;
    logic           w_fill, w_hazard;

    hazard_scoreboard #(
        .REG_AW   (REG_AW),
        .WB_SPLIT (WB_SPLIT)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_hold     (!w_fill && (w_case == ST_FREEZE)),
        .i_kill     (!w_fill && (w_case == ST_FLUSH)),
        .i_load     (!w_fill && (w_case == ST_RUN) && id_reg_write),
        .i_id_valid (id_valid),
        .i_rs1      (id_rs1),
        .i_rs2      (id_rs2),
        .i_use_rs1  (id_use_rs1),
        .i_use_rs2  (id_use_rs2),
        .i_rd       (id_rd),
        .o_hazard   (w_hazard)
    );

    // State and fill-countdown registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FILL;
            r_fill_cnt <= FILL_INIT;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_fill_cnt_nxt;
        end
    end

    // Next state: count down the fill, then record each cycle's decision
    always_comb begin
        w_state_nxt    = r_state;
        w_fill_cnt_nxt = r_fill_cnt;
        if (r_state == ST_FILL) begin
            if (r_fill_cnt == '0) w_state_nxt = ST_RUN;
            else                  w_fill_cnt_nxt = r_fill_cnt - FCW'(1);
        end else begin
            w_state_nxt = w_case;
        end
    end

    // Mealy priority mux: busy > pcsrc > RAW hazard > run
    always_comb begin
        w_fill       = rst || (r_state == ST_FILL);
        w_case       = ST_RUN;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_freeze  = 1'b0;
        if (mem_busy)       w_case = ST_FREEZE;
        else if (mem_pcsrc) w_case = ST_FLUSH;
        else if (w_hazard)  w_case = ST_STALL;
        if (w_fill) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            case (w_case)
                ST_FREEZE: begin
                    pc_we       = 1'b0;
                    if_id_we    = 1'b0;
                    pipe_freeze = 1'b1;
                end
                ST_FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                end
                ST_STALL: begin
                    pc_we       = 1'b0;
                    if_id_we    = 1'b0;
                    id_ex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] r_stall_cnt, r_flush_cnt;

    // Saturating stall/flush event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!w_fill) begin
            if ((w_case == ST_STALL) && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 16'd1;
            if ((w_case == ST_FLUSH) && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic against an in-flight-writer model.
module tb_pipeline_hazard_ctrl;

    localparam int FILL = 4;
    localparam int WBS  = 1;
    localparam int WIN  = (WBS != 0) ? 2 : 3;   // advances a producer blocks readers

    logic        clk = 1'b0;
    logic        rst, id_valid, id_use_rs1, id_use_rs2, id_reg_write, mem_pcsrc, mem_busy;
    logic [2:0]  id_rs1, id_rs2, id_rd;
    logic        pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze;
    logic [15:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_AW(3), .WB_SPLIT(WBS), .FILL_CYC(FILL)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .mem_pcsrc(mem_pcsrc), .mem_busy(mem_busy),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .pipe_freeze(pipe_freeze),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model: writers in flight, each with the number of advances since entering EX
    typedef struct { int rd; int age; } ent_t;
    ent_t q[$];
    int   fill_left = FILL;
    int   m_scnt = 0;
    int   m_fcnt = 0;

    function automatic int perf(input int v);
`ifdef HAZ_PERF_CNT_EN
        return (v > 65535) ? 65535 : v;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check outputs against the model, advance the model
    task automatic apply(input logic r, input logic v, input logic [2:0] rs1, input logic u1,
                         input logic [2:0] rs2, input logic u2, input logic [2:0] rd,
                         input logic w, input logic pc, input logic bz);
        logic [5:0] e;   // {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze}
        bit haz;
        ent_t nq[$];
        @(negedge clk);
        rst = r; id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = w; mem_pcsrc = pc; mem_busy = bz;
        #1;
        haz = 1'b0;
        foreach (q[i])
            if (v && q[i].age < WIN && ((u1 && rs1 == q[i].rd[2:0]) || (u2 && rs2 == q[i].rd[2:0])))
                haz = 1'b1;
        if (r || fill_left > 0) e = 6'b001110;
        else if (bz)            e = 6'b000001;
        else if (pc)            e = 6'b111110;
        else if (haz)           e = 6'b000100;
        else                    e = 6'b110000;
        chk("pc_we",        {15'd0, pc_we},        {15'd0, e[5]});
        chk("if_id_we",     {15'd0, if_id_we},     {15'd0, e[4]});
        chk("if_id_flush",  {15'd0, if_id_flush},  {15'd0, e[3]});
        chk("id_ex_flush",  {15'd0, id_ex_flush},  {15'd0, e[2]});
        chk("ex_mem_flush", {15'd0, ex_mem_flush}, {15'd0, e[1]});
        chk("pipe_freeze",  {15'd0, pipe_freeze},  {15'd0, e[0]});
        chk("stall_cnt", stall_cnt, 16'(perf(m_scnt)));
        chk("flush_cnt", flush_cnt, 16'(perf(m_fcnt)));
        if (r) begin
            fill_left = FILL; q.delete(); m_scnt = 0; m_fcnt = 0;
        end else if (fill_left > 0) begin
            fill_left--;
        end else if (!bz) begin
            if (pc) m_fcnt++;
            else if (haz) m_scnt++;
            foreach (q[i])
                if (!(pc && q[i].age == 0) && q[i].age + 1 < 3)
                    nq.push_back('{q[i].rd, q[i].age + 1});
            q = nq;
            if (!pc && !haz && v && w) q.push_back('{int'(rd), 0});
        end
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_reg_write = 0; mem_pcsrc = 0; mem_busy = 0;
        repeat (2) @(posedge clk);

        // 1: reset and pipeline fill
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("t1_fill_pc_we", {15'd0, pc_we}, 16'd0);
            chk("t1_fill_flush", {13'd0, if_id_flush, id_ex_flush, ex_mem_flush}, 16'd7);
        end
        idle();
        chk("t1_run_pc_we", {15'd0, pc_we}, 16'd1);
        chk("t1_run_if_id_we", {15'd0, if_id_we}, 16'd1);

        // 2: writer r3 then reader of r3 stalls exactly 2 cycles
        apply(0, 1, 0, 0, 0, 0, 3, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            apply(0, 1, 3, 1, 0, 0, 0, 0, 0, 0);
            chk("t2_stall_pc_we", {15'd0, pc_we}, 16'd0);
            chk("t2_stall_bubble", {15'd0, id_ex_flush}, 16'd1);
        end
        apply(0, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        chk("t2_resume_pc_we", {15'd0, pc_we}, 16'd1);
        chk("t2_stall_cnt", stall_cnt, 16'(perf(2)));

        // 3: branch flush beats a hazard and removes the EX producer
        apply(0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
        apply(0, 1, 0, 0, 5, 1, 0, 0, 1, 0);
        chk("t3_flush_all", {13'd0, if_id_flush, id_ex_flush, ex_mem_flush}, 16'd7);
        chk("t3_flush_pc_we", {15'd0, pc_we}, 16'd1);
        apply(0, 1, 0, 0, 5, 1, 0, 0, 0, 0);
        chk("t3_no_stall", {15'd0, pc_we}, 16'd1);
        chk("t3_flush_cnt", flush_cnt, 16'(perf(1)));

        // 4: freeze during a stall, then the stall finishes
        apply(0, 1, 0, 0, 0, 0, 2, 1, 0, 0);
        apply(0, 1, 2, 1, 0, 0, 0, 0, 0, 0);
        chk("t4_stall1", {15'd0, pc_we}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 2, 1, 0, 0, 0, 0, 0, 1);
            chk("t4_freeze", {15'd0, pipe_freeze}, 16'd1);
            chk("t4_freeze_noflush", {13'd0, if_id_flush, id_ex_flush, ex_mem_flush}, 16'd0);
        end
        apply(0, 1, 2, 1, 0, 0, 0, 0, 0, 0);
        chk("t4_stall2", {15'd0, id_ex_flush}, 16'd1);
        apply(0, 1, 2, 1, 0, 0, 0, 0, 0, 0);
        chk("t4_resume", {15'd0, pc_we}, 16'd1);

        // 5: unused rs2 match, and a non-writing producer
        apply(0, 1, 0, 0, 0, 0, 6, 1, 0, 0);
        apply(0, 1, 1, 1, 6, 0, 0, 0, 0, 0);
        chk("t5_unused_rs2", {15'd0, pc_we}, 16'd1);
        apply(0, 1, 0, 0, 0, 0, 4, 0, 0, 0);
        apply(0, 1, 4, 1, 0, 0, 0, 0, 0, 0);
        chk("t5_no_regwrite", {15'd0, pc_we}, 16'd1);

        // 6: reset in the middle of a stall
        apply(0, 1, 0, 0, 0, 0, 7, 1, 0, 0);
        apply(0, 1, 7, 1, 0, 0, 0, 0, 0, 0);
        chk("t6_stall", {15'd0, pc_we}, 16'd0);
        apply(1, 1, 7, 1, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 7, 1, 0, 0, 0, 0, 0, 0);
        chk("t6_fill", {13'd0, if_id_flush, id_ex_flush, ex_mem_flush}, 16'd7);
        chk("t6_stall_cnt0", stall_cnt, 16'd0);
        chk("t6_flush_cnt0", flush_cnt, 16'd0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            apply(($urandom_range(99) < 2), ($urandom_range(3) != 0),
                  3'($urandom_range(7)), 1'($urandom_range(1)),
                  3'($urandom_range(7)), 1'($urandom_range(1)),
                  3'($urandom_range(7)), 1'($urandom_range(1)),
                  ($urandom_range(99) < 8), ($urandom_range(99) < 10));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
